// File: rtl/jpeg_akis_denetleyici_pkg.sv
// Shared types and marker constants for the JPEG stream sequencer.
// The decode-side FSM states, the JPEG marker codes and the error codes all live here.
package jpeg_akis_denetleyici_pkg;

    typedef enum logic [3:0] {
        BOSTA,
        SOI_FF,
        SOI_D8,
        MRK_FF,
        MRK_KOD,
        UZ_H,
        UZ_L,
        ATLA,
        VERI,
        DRENAJ,
        BITTI
    } durum_t;

    localparam logic [7:0] MRK_ONEK = 8'hFF;
    localparam logic [7:0] MRK_SOI  = 8'hD8;
    localparam logic [7:0] MRK_EOI  = 8'hD9;
    localparam logic [7:0] MRK_SOS  = 8'hDA;
    localparam logic [7:0] MRK_TEM  = 8'h01;

    localparam logic [1:0] HATA_YOK    = 2'd0;
    localparam logic [1:0] HATA_SOI    = 2'd1;
    localparam logic [1:0] HATA_BASLIK = 2'd2;
    localparam logic [1:0] HATA_TARAMA = 2'd3;

    // RSTn markers occupy D0..D7, so only the low three bits vary.
    function automatic logic rst_mi(input logic [7:0] kod);
        return kod[7:3] == 5'b11010;
    endfunction

endpackage

// File: rtl/jpeg_akis_denetleyici_dolgu.sv
// Scan-phase FF00 de-stuffer with a single-entry output register.
// Flags EOI and illegal in-scan markers as one-cycle strobes back to the sequencer.
module jpeg_dolgu_ayiklayici
    import jpeg_akis_denetleyici_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       etkin,
    input  logic [7:0] s_veri,
    input  logic       s_gecerli,
    output logic       s_hazir,
    output logic [7:0] m_veri,
    output logic       m_gecerli,
    input  logic       m_hazir,
    output logic       eoi,
    output logic       hata
);

    logic       ff_bekle;
    logic       ff_bekle_d;
    logic       kabul;
    logic       ilet;
    logic [7:0] ilet_veri;

    // A new byte fits whenever the register is empty or is being emptied this cycle.
    assign s_hazir = etkin & (~m_gecerli | m_hazir);
    assign kabul   = s_gecerli & s_hazir;

    always_comb begin
        ilet       = 1'b0;
        ilet_veri  = s_veri;
        ff_bekle_d = ff_bekle;
        eoi        = 1'b0;
        hata       = 1'b0;
        if (kabul) begin
            if (!ff_bekle) begin
                if (s_veri == MRK_ONEK) ff_bekle_d = 1'b1;
                else                    ilet       = 1'b1;
            end else if (s_veri == 8'h00) begin
                ilet       = 1'b1;
                ilet_veri  = MRK_ONEK;
                ff_bekle_d = 1'b0;
            end else if (s_veri == MRK_ONEK) begin
                ff_bekle_d = 1'b1;
            end else if (rst_mi(s_veri)) begin
                ff_bekle_d = 1'b0;
            end else if (s_veri == MRK_EOI) begin
                eoi        = 1'b1;
                ff_bekle_d = 1'b0;
            end else begin
                hata       = 1'b1;
                ff_bekle_d = 1'b0;
            end
        end
    end

    // An in-scan error discards whatever is still waiting in the register.
    always_ff @(posedge clk) begin
        if (rst || hata) begin
            ff_bekle  <= 1'b0;
            m_gecerli <= 1'b0;
            m_veri    <= 8'h00;
        end else begin
            ff_bekle <= ff_bekle_d;
            if (ilet) begin
                m_veri    <= ilet_veri;
                m_gecerli <= 1'b1;
            end else if (m_hazir) begin
                m_gecerli <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jpeg_akis_denetleyici.sv
// Frame sequencer ahead of the JPEG decoder: checks SOI, skips header segments through SOS,
// streams de-stuffed scan bytes out and reports completion once EOI and all pixels are seen.
module jpeg_akis_denetleyici
    import jpeg_akis_denetleyici_pkg::*;
#(
    parameter int BOYUT_BIT  = 12,
    parameter int PIKSEL_BIT = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baslat_i,
    input  logic [BOYUT_BIT-1:0] genislik_i,
    input  logic [BOYUT_BIT-1:0] yukseklik_i,
    input  logic [7:0]           s_veri_i,
    input  logic                 s_gecerli_i,
    output logic                 s_hazir_o,
    output logic [7:0]           m_veri_o,
    output logic                 m_gecerli_o,
    input  logic                 m_hazir_i,
    input  logic                 coz_gecerli_i,
    input  logic                 coz_hazir_i,
    output logic                 mesgul_o,
    output logic                 bitti_o,
    output logic                 hata_o,
    output logic [1:0]           hata_kodu_o
);

    durum_t                durum;
    logic [PIKSEL_BIT-1:0] hedef;
    logic [PIKSEL_BIT-1:0] pikseller;
    logic [15:0]           kalan;
    logic [15:0]           uzunluk;
    logic [7:0]            uz_yuksek;
    logic                  sos_mi;
    logic                  baslik_hazir;
    logic                  baslik_kabul;
    logic                  veri_hazir;
    logic                  eoi;
    logic                  tarama_hatasi;
    logic                  hata_var;
    logic [1:0]            yeni_kod;

    assign baslik_hazir = durum inside {SOI_FF, SOI_D8, MRK_FF, MRK_KOD, UZ_H, UZ_L, ATLA};
    assign baslik_kabul = baslik_hazir & s_gecerli_i;
    assign s_hazir_o    = baslik_hazir | veri_hazir;
    assign uzunluk      = {uz_yuksek, s_veri_i};

    jpeg_dolgu_ayiklayici u_dolgu (
        .clk       (clk_i),
        .rst       (rst_i),
        .etkin     (durum == VERI),
        .s_veri    (s_veri_i),
        .s_gecerli (s_gecerli_i),
        .s_hazir   (veri_hazir),
        .m_veri    (m_veri_o),
        .m_gecerli (m_gecerli_o),
        .m_hazir   (m_hazir_i),
        .eoi       (eoi),
        .hata      (tarama_hatasi)
    );

    // Header validation: a bad byte is still consumed, but the frame is abandoned.
    always_comb begin
        hata_var = 1'b0;
        yeni_kod = HATA_BASLIK;
        if (tarama_hatasi) begin
            hata_var = 1'b1;
            yeni_kod = HATA_TARAMA;
        end else if (baslik_kabul) begin
            case (durum)
                SOI_FF:  if (s_veri_i != MRK_ONEK) begin hata_var = 1'b1; yeni_kod = HATA_SOI; end
                SOI_D8:  if (s_veri_i != MRK_SOI)  begin hata_var = 1'b1; yeni_kod = HATA_SOI; end
                MRK_FF:  if (s_veri_i != MRK_ONEK) hata_var = 1'b1;
                MRK_KOD: if (s_veri_i inside {MRK_SOI, MRK_EOI, MRK_TEM} || rst_mi(s_veri_i)) hata_var = 1'b1;
                UZ_L:    if (uzunluk < 16'd2) hata_var = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum       <= BOSTA;
            hedef       <= '0;
            pikseller   <= '0;
            kalan       <= '0;
            uz_yuksek   <= '0;
            sos_mi      <= 1'b0;
            mesgul_o    <= 1'b0;
            bitti_o     <= 1'b0;
            hata_o      <= 1'b0;
            hata_kodu_o <= HATA_YOK;
        end else begin
            bitti_o <= 1'b0;
            if (durum != BOSTA && pikseller != hedef && coz_gecerli_i && coz_hazir_i)
                pikseller <= pikseller + PIKSEL_BIT'(1);
            if (hata_var) begin
                durum       <= BOSTA;
                mesgul_o    <= 1'b0;
                hata_o      <= 1'b1;
                hata_kodu_o <= yeni_kod;
            end else begin
                case (durum)
                    BOSTA: if (baslat_i) begin
                        hedef       <= PIKSEL_BIT'(genislik_i) * PIKSEL_BIT'(yukseklik_i);
                        pikseller   <= '0;
                        hata_o      <= 1'b0;
                        hata_kodu_o <= HATA_YOK;
                        mesgul_o    <= 1'b1;
                        durum       <= SOI_FF;
                    end
                    SOI_FF: if (baslik_kabul) durum <= SOI_D8;
                    SOI_D8: if (baslik_kabul) durum <= MRK_FF;
                    MRK_FF: if (baslik_kabul) durum <= MRK_KOD;
                    MRK_KOD: if (baslik_kabul && s_veri_i != MRK_ONEK) begin
                        sos_mi <= (s_veri_i == MRK_SOS);
                        durum  <= UZ_H;
                    end
                    UZ_H: if (baslik_kabul) begin
                        uz_yuksek <= s_veri_i;
                        durum     <= UZ_L;
                    end
                    // A length of exactly two means an empty payload, so ATLA is bypassed.
                    UZ_L: if (baslik_kabul) begin
                        kalan <= uzunluk - 16'd2;
                        if (uzunluk == 16'd2) durum <= sos_mi ? VERI : MRK_FF;
                        else                  durum <= ATLA;
                    end
                    ATLA: if (baslik_kabul) begin
                        kalan <= kalan - 16'd1;
                        if (kalan == 16'd1) durum <= sos_mi ? VERI : MRK_FF;
                    end
                    VERI: if (eoi) durum <= DRENAJ;
                    DRENAJ: if (!m_gecerli_o && pikseller == hedef) begin
                        durum    <= BITTI;
                        bitti_o  <= 1'b1;
                        mesgul_o <= 1'b0;
                    end
                    BITTI:   durum <= BOSTA;
                    default: durum <= BOSTA;
                endcase
            end
        end
    end

endmodule
